// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word at a time from imem and
// presents it to decode. Optional macro FETCH_COUNT_EN adds a retired-fetch counter port.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic        instr_valid,
    input  logic        instr_ack,
    input  logic        branch,
    input  logic        jump,
    input  logic        zero,
    output logic [31:0] pc_plus4
`ifdef FETCH_COUNT_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_plus4_w;
    logic [31:0] br_off_w;
    logic [31:0] next_pc_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    // Jump wins outright so an undefined branch flag cannot leak into the target.
    always_comb begin
        pc_plus4_w = pc_q + 32'd4;
        br_off_w   = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
        if (jump)
            next_pc_w = {pc_plus4_w[31:28], instr_q[25:0], 2'b00};
        else if (branch && zero)
            next_pc_w = pc_plus4_w + br_off_w;
        else
            next_pc_w = pc_plus4_w;
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            IDLE:  state_d = FETCH;
            FETCH: begin
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (instr_ack) begin
                    pc_d    = next_pc_w;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        imem_req    = (state_q == FETCH);
        instr_valid = (state_q == HOLD);
        imem_addr   = pc_q;
        instr       = instr_q;
        opcode      = instr_q[31:26];
        funct       = instr_q[5:0];
        pc_plus4    = pc_plus4_w;
    end

`ifdef FETCH_COUNT_EN
    logic [31:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (state_q == HOLD && instr_ack)
            cnt_q <= cnt_q + 32'd1;
    end

    assign fetch_count = cnt_q;
`endif

endmodule
